// File: rtl/csel_pkg.sv
// Shared widths and stage-1 record for the carry-select subtractor.
// Sign-bit fields exist only when SUB_OVF_EN is defined.
package csel_pkg;

    localparam int CSEL_W   = 8;
    localparam int CSEL_SEG = 4;

    typedef struct packed {
        logic [CSEL_SEG-1:0] lo_diff;
        logic                lo_c;
        logic [CSEL_SEG-1:0] hi_d0;
        logic                hi_c0;
        logic [CSEL_SEG-1:0] hi_d1;
        logic                hi_c1;
`ifdef SUB_OVF_EN
        logic                a_msb;
        logic                b_msb;
`endif
    } stage1_t;

endpackage

// File: rtl/nib_add4.sv
// 4-bit ripple-carry adder with carry-in; the building block of each
// carry-select segment.
module nib_add4
    import csel_pkg::*;
(
    input  logic [CSEL_SEG-1:0] a,
    input  logic [CSEL_SEG-1:0] b,
    input  logic                cin,
    output logic [CSEL_SEG-1:0] sum,
    output logic                cout
);

    logic [CSEL_SEG:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CSEL_SEG; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CSEL_SEG];

endmodule

// File: rtl/csel_sub8_pipe.sv
// Two-stage valid/ready pipelined 8-bit subtractor (a + ~b + 1) using a
// carry-select high nibble. Define SUB_OVF_EN to add the signed ovf output.
module csel_sub8_pipe
    import csel_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CSEL_W-1:0] a,
    input  logic [CSEL_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CSEL_W-1:0] diff,
    output logic              bout
`ifdef SUB_OVF_EN
    ,
    output logic              ovf
`endif
);

    logic [CSEL_W-1:0]   b_n;
    logic [CSEL_SEG-1:0] lo_diff, hi_d0, hi_d1;
    logic                lo_c, hi_c0, hi_c1;

    stage1_t             s1_q;
    logic                s1_v;
    logic                s2_v;
    logic [CSEL_W-1:0]   diff_q;
    logic                bout_q;
    logic                s1_adv, s2_adv;
    logic [CSEL_SEG-1:0] hi_sel;
    logic                c_sel;

    assign b_n = ~b;

    nib_add4 u_lo (
        .a    (a[CSEL_SEG-1:0]),
        .b    (b_n[CSEL_SEG-1:0]),
        .cin  (1'b1),
        .sum  (lo_diff),
        .cout (lo_c)
    );

    nib_add4 u_hi0 (
        .a    (a[CSEL_W-1:CSEL_SEG]),
        .b    (b_n[CSEL_W-1:CSEL_SEG]),
        .cin  (1'b0),
        .sum  (hi_d0),
        .cout (hi_c0)
    );

    nib_add4 u_hi1 (
        .a    (a[CSEL_W-1:CSEL_SEG]),
        .b    (b_n[CSEL_W-1:CSEL_SEG]),
        .cin  (1'b1),
        .sum  (hi_d1),
        .cout (hi_c1)
    );

    // A stage moves when it has room or its downstream is draining this cycle.
    assign s2_adv   = !s2_v || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;

    assign hi_sel = s1_q.lo_c ? s1_q.hi_d1 : s1_q.hi_d0;
    assign c_sel  = s1_q.lo_c ? s1_q.hi_c1 : s1_q.hi_c0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_q.lo_diff <= lo_diff;
                s1_q.lo_c    <= lo_c;
                s1_q.hi_d0   <= hi_d0;
                s1_q.hi_c0   <= hi_c0;
                s1_q.hi_d1   <= hi_d1;
                s1_q.hi_c1   <= hi_c1;
`ifdef SUB_OVF_EN
                s1_q.a_msb   <= a[CSEL_W-1];
                s1_q.b_msb   <= b[CSEL_W-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                diff_q <= {hi_sel, s1_q.lo_diff};
                bout_q <= ~c_sel;
            end
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s2_adv && s1_v) begin
            ovf_q <= (s1_q.a_msb != s1_q.b_msb) && (hi_sel[CSEL_SEG-1] != s1_q.a_msb);
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = s2_v;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: doc/csel_sub8_pipe.md
CSEL_SUB8_PIPE -- requirements
Module: csel_sub8_pipe

Interface
REQ-001 SHALL have no parameters; operand width (8) and segment width (4) come from the shared package.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port: in_valid  input  1  operand pair offered.
REQ-005 SHALL provide port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL provide ports: a  input  8  minuend; b  input  8  subtrahend.
REQ-007 SHALL provide port: out_valid  output  1  result available.
REQ-008 SHALL provide port: out_ready  input  1  consumer accepts result.
REQ-009 SHALL provide ports: diff  output  8  a - b modulo 256; bout  output  1  unsigned borrow, high when a < b.
REQ-010 SHALL provide port ovf  output  1  signed overflow, only when SUB_OVF_EN is defined.

Function
REQ-011 SHALL compute diff = a + ~b + 1 modulo 256 and bout = NOT(carry out of that sum).
REQ-012 SHALL use the carry-select scheme: low nibble with carry-in 1; high nibble computed twice (carry-in 0 and 1), selected by the low-nibble carry.
REQ-013 Stage 1 SHALL register the low-nibble difference, low-nibble carry, and both high-nibble candidates with their carries.
REQ-014 Stage 2 SHALL register the selected high nibble, the concatenated diff, and bout.
REQ-015 Transfer SHALL occur on in_valid && in_ready at input and out_valid && out_ready at output.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled.
REQ-017 Throughput SHALL be one result per cycle while out_ready is held high.
REQ-018 Stage 2 SHALL advance when it is empty or out_ready=1.
REQ-019 Stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-020 in_ready SHALL equal (stage 1 empty OR stage 1 advances), combinationally from out_ready.
REQ-021 While out_valid=1 and out_ready=0, diff, bout and ovf SHALL hold stable.
REQ-022 With both stages full and out_ready=0, in_ready SHALL be 0 and no operand SHALL be lost or duplicated.
REQ-023 With both stages full and out_ready=1, in_valid=1: output, internal shift and input acceptance SHALL all happen in the same cycle.
REQ-024 a=b SHALL give diff=0x00, bout=0.
REQ-025 a=0x00, b=0xFF SHALL give diff=0x01, bout=1.

Reset
REQ-026 On a clock edge with rst_n=0, both stage-valid flags SHALL clear to 0.
REQ-027 On that reset, diff, bout, ovf and all stage data registers SHALL clear to 0.
REQ-028 After that reset, out_valid=0 and in_ready=1 from the next cycle.
REQ-029 Reset mid-operation SHALL discard in-flight results with no output transfer for them.
REQ-030 in_valid during reset SHALL be ignored.

Configuration
REQ-031 Macro SUB_OVF_EN defined: ovf port SHALL exist.
REQ-032 ovf = (a[7] != b[7]) && (diff[7] != a[7]), pipelined aligned with diff (a[7], b[7] carried through stage 1).
REQ-033 Macro SUB_OVF_EN undefined: ovf port and its registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 Package csel_pkg SHALL hold constants CSEL_W=8 and CSEL_SEG=4.
REQ-035 csel_pkg SHALL hold a stage-1 struct typedef: low diff, low carry, hi diff0/carry0, hi diff1/carry1, sign bits.
REQ-036 Sub-module nib_add4 (4-bit ripple add with carry-in, sum and carry-out) SHALL be instantiated three times.
REQ-037 Pipeline control SHALL live in csel_sub8_pipe.

Verification
REQ-038 a=0x50, b=0x20, out_ready=1 -> 2 cycles later diff=0x30, bout=0.
REQ-039 a=0x10, b=0x01 (borrow across nibble) -> diff=0x0F, bout=0.
REQ-040 a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-041 Back-to-back stream of 8 pairs, out_ready low cycles 3-5 -> in_ready low once both stages are full; all 8 results in order with no loss or duplicates; diff stable while stalled.
REQ-042 Two operands in flight, rst_n=0 one cycle -> out_valid=0 next cycle, no stale result ever emitted.
REQ-043 With SUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
